ddr_slave_mem: RTL and testbench

//  AXI4 full-protocol memory-backed slave; the responder end of the ddr_master AXI4 master port.

---
 rtl/ddr_axi_pkg.sv | 37 +++
 rtl/ddr_slave_ram.sv | 42 ++++
 rtl/ddr_slave_mem.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_ddr_slave_mem.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_axi_pkg.sv
// Shared AXI4 encodings, FSM states and burst helpers for the DDR slave memory.
package ddr_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } r_state_e;

    // Burst control latched at the address handshake.
    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } axi_ctl_t;

    // Per-beat address increment; WRAP and reserved encodings advance like INCR.
    function automatic logic [7:0] burst_step(input logic [1:0] burst, input logic [2:0] size);
        return (burst == BURST_FIXED) ? 8'd0 : (8'd1 << size);
    endfunction

endpackage

// File: rtl/ddr_slave_ram.sv
// Simple dual-port RAM: byte-write write port, registered read port that holds when not enabled.
module ddr_slave_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    re,
    input  logic [AW-1:0]           raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-strobed write; storage is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read-first registered read; output holds its last value while re is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ddr_slave_mem.sv
// AXI4 memory-backed slave with independent write and read engines, one burst per direction.
// Optional build macro: DDR_SLAVE_RANGE_CHECK_EN (flag beats beyond the memory with SLVERR).
module ddr_slave_mem
    import ddr_axi_pkg::*;
#(
    parameter int unsigned ID_WIDTH    = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned BUSER_WIDTH = 1,
    parameter int unsigned RUSER_WIDTH = 1
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    input  logic [ID_WIDTH-1:0]     s00_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [7:0]              s00_axi_awlen,
    input  logic [2:0]              s00_axi_awsize,
    input  logic [1:0]              s00_axi_awburst,
    input  logic                    s00_axi_awvalid,
    output logic                    s00_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                    s00_axi_wlast,
    input  logic                    s00_axi_wvalid,
    output logic                    s00_axi_wready,
    output logic [ID_WIDTH-1:0]     s00_axi_bid,
    output logic [1:0]              s00_axi_bresp,
    output logic [BUSER_WIDTH-1:0]  s00_axi_buser,
    output logic                    s00_axi_bvalid,
    input  logic                    s00_axi_bready,
    input  logic [ID_WIDTH-1:0]     s00_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [7:0]              s00_axi_arlen,
    input  logic [2:0]              s00_axi_arsize,
    input  logic [1:0]              s00_axi_arburst,
    input  logic                    s00_axi_arvalid,
    output logic                    s00_axi_arready,
    output logic [ID_WIDTH-1:0]     s00_axi_rid,
    output logic [DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]              s00_axi_rresp,
    output logic                    s00_axi_rlast,
    output logic [RUSER_WIDTH-1:0]  s00_axi_ruser,
    output logic                    s00_axi_rvalid,
    input  logic                    s00_axi_rready
);

    localparam int unsigned LSB   = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

    // Write engine state
    w_state_e              w_state, w_state_n;
    logic [ID_WIDTH-1:0]   aw_id_q, aw_id_n;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_n;
    axi_ctl_t              aw_ctl_q, aw_ctl_n;
    logic [7:0]            w_cnt_q, w_cnt_n;
    logic                  w_err_q, w_err_n;
    logic                  awready_q, awready_n;
    logic                  wready_q, wready_n;
    logic                  bvalid_q, bvalid_n;
    logic [ID_WIDTH-1:0]   bid_q, bid_n;
    logic [1:0]            bresp_q, bresp_n;
    logic                  w_last_beat_c;
    logic                  w_in_range_c;
    logic                  ram_we_c;

    // Read engine state
    r_state_e              r_state, r_state_n;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_n;
    axi_ctl_t              ar_ctl_q, ar_ctl_n;
    logic [7:0]            r_cnt_q, r_cnt_n;
    logic                  arready_q, arready_n;
    logic                  rvalid_q, rvalid_n;
    logic                  rlast_q, rlast_n;
    logic [1:0]            rresp_q, rresp_n;
    logic [ID_WIDTH-1:0]   rid_q, rid_n;
    logic                  r_in_range_c;
    logic                  ram_re_c;
    logic [DATA_WIDTH-1:0] ram_rdata;

`ifdef DDR_SLAVE_RANGE_CHECK_EN
    assign w_in_range_c = (aw_addr_q >> (IDX_W + LSB)) == '0;
    assign r_in_range_c = (r_addr_q >> (IDX_W + LSB)) == '0;
    // Out-of-range read beats present zero data alongside their SLVERR.
    assign s00_axi_rdata = (rresp_q == RESP_SLVERR) ? '0 : ram_rdata;
`else
    assign w_in_range_c = 1'b1;
    assign r_in_range_c = 1'b1;
    assign s00_axi_rdata = ram_rdata;
`endif

    assign w_last_beat_c = (w_cnt_q == aw_ctl_q.len);

    // Write engine next-state and registered-output values.
    always_comb begin
        w_state_n = w_state;
        aw_id_n   = aw_id_q;
        aw_addr_n = aw_addr_q;
        aw_ctl_n  = aw_ctl_q;
        w_cnt_n   = w_cnt_q;
        w_err_n   = w_err_q;
        awready_n = awready_q;
        wready_n  = wready_q;
        bvalid_n  = bvalid_q;
        bid_n     = bid_q;
        bresp_n   = bresp_q;
        ram_we_c  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready_n = 1'b1;
                if (s00_axi_awvalid && awready_q) begin
                    aw_id_n   = s00_axi_awid;
                    aw_addr_n = s00_axi_awaddr;
                    aw_ctl_n  = '{len: s00_axi_awlen, size: s00_axi_awsize, burst: s00_axi_awburst};
                    w_cnt_n   = 8'd0;
                    w_err_n   = 1'b0;
                    awready_n = 1'b0;
                    wready_n  = 1'b1;
                    w_state_n = W_DATA;
                end
            end
            W_DATA: begin
                if (s00_axi_wvalid && wready_q) begin
                    ram_we_c  = w_in_range_c;
                    w_err_n   = w_err_q | (s00_axi_wlast != w_last_beat_c) | ~w_in_range_c;
                    aw_addr_n = aw_addr_q + ADDR_WIDTH'(burst_step(aw_ctl_q.burst, aw_ctl_q.size));
                    w_cnt_n   = w_cnt_q + 8'd1;
                    if (w_last_beat_c) begin
                        wready_n  = 1'b0;
                        bvalid_n  = 1'b1;
                        bid_n     = aw_id_q;
                        bresp_n   = w_err_n ? RESP_SLVERR : RESP_OKAY;
                        w_state_n = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && s00_axi_bready) begin
                    bvalid_n  = 1'b0;
                    bresp_n   = RESP_OKAY;
                    awready_n = 1'b1;
                    w_state_n = W_IDLE;
                end
            end
            default: begin
                w_state_n = W_IDLE;
            end
        endcase
    end

    // Write engine registers; reset discards any burst in flight.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            w_state   <= W_IDLE;
            aw_id_q   <= '0;
            aw_addr_q <= '0;
            aw_ctl_q  <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state   <= w_state_n;
            aw_id_q   <= aw_id_n;
            aw_addr_q <= aw_addr_n;
            aw_ctl_q  <= aw_ctl_n;
            w_cnt_q   <= w_cnt_n;
            w_err_q   <= w_err_n;
            awready_q <= awready_n;
            wready_q  <= wready_n;
            bvalid_q  <= bvalid_n;
            bid_q     <= bid_n;
            bresp_q   <= bresp_n;
        end
    end

    // Read engine next-state; RAM reads issue in FETCH and on each non-last beat handshake.
    always_comb begin
        r_state_n = r_state;
        r_addr_n  = r_addr_q;
        ar_ctl_n  = ar_ctl_q;
        r_cnt_n   = r_cnt_q;
        arready_n = arready_q;
        rvalid_n  = rvalid_q;
        rlast_n   = rlast_q;
        rresp_n   = rresp_q;
        rid_n     = rid_q;
        ram_re_c  = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready_n = 1'b1;
                if (s00_axi_arvalid && arready_q) begin
                    rid_n     = s00_axi_arid;
                    r_addr_n  = s00_axi_araddr;
                    ar_ctl_n  = '{len: s00_axi_arlen, size: s00_axi_arsize, burst: s00_axi_arburst};
                    r_cnt_n   = 8'd0;
                    arready_n = 1'b0;
                    r_state_n = R_FETCH;
                end
            end
            R_FETCH: begin
                ram_re_c  = 1'b1;
                r_addr_n  = r_addr_q + ADDR_WIDTH'(burst_step(ar_ctl_q.burst, ar_ctl_q.size));
                rvalid_n  = 1'b1;
                rlast_n   = (ar_ctl_q.len == 8'd0);
                rresp_n   = r_in_range_c ? RESP_OKAY : RESP_SLVERR;
                r_state_n = R_DATA;
            end
            R_DATA: begin
                if (rvalid_q && s00_axi_rready) begin
                    if (rlast_q) begin
                        rvalid_n  = 1'b0;
                        rlast_n   = 1'b0;
                        rresp_n   = RESP_OKAY;
                        arready_n = 1'b1;
                        r_state_n = R_IDLE;
                    end else begin
                        ram_re_c = 1'b1;
                        r_addr_n = r_addr_q + ADDR_WIDTH'(burst_step(ar_ctl_q.burst, ar_ctl_q.size));
                        r_cnt_n  = r_cnt_q + 8'd1;
                        rlast_n  = (r_cnt_n == ar_ctl_q.len);
                        rresp_n  = r_in_range_c ? RESP_OKAY : RESP_SLVERR;
                    end
                end
            end
            default: begin
                r_state_n = R_IDLE;
            end
        endcase
    end

    // Read engine registers; reset discards any burst in flight.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_state   <= R_IDLE;
            r_addr_q  <= '0;
            ar_ctl_q  <= '0;
            r_cnt_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= '0;
        end else begin
            r_state   <= r_state_n;
            r_addr_q  <= r_addr_n;
            ar_ctl_q  <= ar_ctl_n;
            r_cnt_q   <= r_cnt_n;
            arready_q <= arready_n;
            rvalid_q  <= rvalid_n;
            rlast_q   <= rlast_n;
            rresp_q   <= rresp_n;
            rid_q     <= rid_n;
        end
    end

    ddr_slave_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .AW         (IDX_W)
    ) u_ram (
        .clk   (s00_axi_aclk),
        .rst_n (s00_axi_aresetn),
        .we    (ram_we_c),
        .waddr (aw_addr_q[IDX_W+LSB-1:LSB]),
        .wdata (s00_axi_wdata),
        .wstrb (s00_axi_wstrb),
        .re    (ram_re_c),
        .raddr (r_addr_q[IDX_W+LSB-1:LSB]),
        .rdata (ram_rdata)
    );

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bid     = bid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_buser   = '0;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rlast   = rlast_q;
    assign s00_axi_rresp   = rresp_q;
    assign s00_axi_rid     = rid_q;
    assign s00_axi_ruser   = '0;

endmodule

// File: tb/tb_ddr_slave_mem.sv
// Randomized bench for ddr_slave_mem against a byte-level memory model.
module tb_ddr_slave_mem;

`ifdef DDR_SLAVE_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk;
    logic        aresetn;
    logic [3:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wvalid, wready, wlast;
    logic [3:0]  wstrb;
    logic        bvalid, bready, arvalid, arready, rvalid, rready, rlast;
    logic [0:0]  buser, ruser;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_m [1024];
    logic [3:0]  kn_m  [1024];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    ddr_slave_mem dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
        .s00_axi_awid(awid), .s00_axi_awaddr(awaddr), .s00_axi_awlen(awlen),
        .s00_axi_awsize(awsize), .s00_axi_awburst(awburst),
        .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wlast(wlast),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bid(bid), .s00_axi_bresp(bresp), .s00_axi_buser(buser),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_arid(arid), .s00_axi_araddr(araddr), .s00_axi_arlen(arlen),
        .s00_axi_arsize(arsize), .s00_axi_arburst(arburst),
        .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rid(rid), .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
        .s00_axi_rlast(rlast), .s00_axi_ruser(ruser),
        .s00_axi_rvalid(rvalid), .s00_axi_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
                                              input logic [2:0] size, input logic [1:0] burst);
        if (burst == 2'b00) return a;
        return a + 32'(i) * (32'd1 << size);
    endfunction

    function automatic bit in_range_m(input logic [31:0] a);
        return !RC || (a < 32'd4096);
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] k);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{k[b]}};
        return m;
    endfunction

    // Burst write from wd/ws; wlast goes high on beat last_at; w_first raises W three cycles before AW.
    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int last_at, input bit w_first);
        int n;
        logic [31:0] ba;
        int w;
        bit err;
        err = (last_at != len);
        if (w_first) begin
            wvalid = 1'b1; wdata = wd[0]; wstrb = ws[0]; wlast = (last_at == 0);
            repeat (3) begin
                chk("wready_before_aw", wready, 1'b0);
                @(negedge clk);
            end
        end
        awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin chk("aw_timeout", 1'b0, 1'b1); awvalid = 1'b0; wvalid = 1'b0; return; end
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_at);
            n = 0;
            while (!wready && n < 200) begin @(negedge clk); n++; end
            if (n >= 200) begin chk("w_timeout", 1'b0, 1'b1); wvalid = 1'b0; return; end
            ba = beat_addr(addr, i, size, burst);
            if (in_range_m(ba)) begin
                w = int'((ba >> 2) & 32'd1023);
                for (int b = 0; b < 4; b++) begin
                    if (ws[i][b]) begin
                        mem_m[w][b*8 +: 8] = wd[i][b*8 +: 8];
                        kn_m[w][b] = 1'b1;
                    end
                end
            end else begin
                err = 1'b1;
            end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 200) begin @(negedge clk); n++; end
        chk("bvalid", bvalid, 1'b1);
        chk("bid", bid, id);
        chk("bresp", bresp, err ? 2'b10 : 2'b00);
        @(negedge clk);
        bready = 1'b0;
    endtask

    // Burst read checked beat by beat; stall 0=none 1=toggle 2=random; abort_at asserts reset on that beat.
    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int stall, input int pre, input int abort_at);
        int n, b, lat, w;
        logic [31:0] ba, held, mask, exp_d;
        bit was_stalled, ok;
        repeat (pre) @(negedge clk);
        arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
        rready = (stall == 0);
        n = 0;
        while (!arready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin chk("ar_timeout", 1'b0, 1'b1); arvalid = 1'b0; return; end
        @(negedge clk);
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 200) begin @(negedge clk); lat++; end
        chk("r_latency", 32'(lat), 32'd2);
        if (!rvalid) return;
        b = 0; n = 0; was_stalled = 1'b0; held = '0;
        while (b <= len && n < 1000) begin
            n++;
            chk("rvalid", rvalid, 1'b1);
            if (was_stalled) chk("rdata_hold", rdata, held);
            ba = beat_addr(addr, b, size, burst);
            ok = in_range_m(ba);
            w = int'((ba >> 2) & 32'd1023);
            mask  = ok ? byte_mask(kn_m[w]) : 32'hFFFF_FFFF;
            exp_d = ok ? mem_m[w] : 32'h0;
            if (mask != 0) chk($sformatf("rdata_b%0d", b), rdata & mask, exp_d & mask);
            chk("rresp", rresp, ok ? 2'b00 : 2'b10);
            chk("rlast", rlast, (b == len));
            chk("rid", rid, id);
            if (b == abort_at) begin
                aresetn = 1'b0;
                #1;
                chk("rvalid_in_reset", rvalid, 1'b0);
                chk("rlast_in_reset", rlast, 1'b0);
                chk("arready_in_reset", arready, 1'b0);
                rready = 1'b0;
                return;
            end
            if (stall == 1)      rready = n[0];
            else if (stall == 2) rready = 1'($urandom_range(0, 1));
            else                 rready = 1'b1;
            held = rdata;
            was_stalled = !rready;
            if (rready) b++;
            @(negedge clk);
        end
        if (b <= len) chk("r_timeout", 1'b0, 1'b1);
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int len, last_at;
        logic [2:0] sz;
        logic [1:0] bu;
        for (int i = 0; i < 1024; i++) begin mem_m[i] = '0; kn_m[i] = '0; end
        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_awready", awready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rlast", rlast, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_bid_rid", {bid, rid}, 8'h00);
        aresetn = 1'b1;
        @(negedge clk);
        chk("awready_after_rst", awready, 1'b1);
        chk("arready_after_rst", arready, 1'b1);

        // Single beat
        wd[0] = 32'hA5A5_5A5A; ws[0] = 4'hF;
        axi_write(4'h1, 32'h10, 0, 3'd2, 2'b01, 0, 1'b0);
        axi_read(4'h2, 32'h10, 0, 3'd2, 2'b01, 0, 0, -1);

        // INCR 16 beats: toggled then unstalled read-back
        for (int i = 0; i < 16; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; end
        axi_write(4'h5, 32'h100, 15, 3'd2, 2'b01, 15, 1'b0);
        axi_read(4'h6, 32'h100, 15, 3'd2, 2'b01, 1, 0, -1);
        axi_read(4'h7, 32'h100, 15, 3'd2, 2'b01, 0, 0, -1);

        // FIXED burst with one strobed lane per beat
        for (int i = 0; i < 4; i++) begin
            wd[i] = $urandom;
            wd[i][i*8 +: 8] = 8'(8'h11 * (i + 1));
            ws[i] = 4'(1 << i);
        end
        axi_write(4'h8, 32'h40, 3, 3'd2, 2'b00, 3, 1'b0);
        axi_read(4'h9, 32'h40, 0, 3'd2, 2'b01, 0, 0, -1);

        // AW and AR in the same cycle, W offered three cycles ahead of AW
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        fork
            axi_write(4'hA, 32'h300, 3, 3'd2, 2'b01, 3, 1'b1);
            axi_read(4'hB, 32'h104, 3, 3'd2, 2'b01, 2, 3, -1);
        join
        axi_read(4'hC, 32'h300, 3, 3'd2, 2'b10, 0, 0, -1);

        // wlast early on beat 2 of a 4-beat burst
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        axi_write(4'hD, 32'h500, 3, 3'd2, 2'b01, 2, 1'b0);
        axi_read(4'hE, 32'h500, 3, 3'd2, 2'b11, 0, 0, -1);

        if (RC) begin
            wd[0] = $urandom; ws[0] = 4'hF;
            axi_write(4'h3, 32'hFFC, 0, 3'd2, 2'b01, 0, 1'b0);
            axi_read(4'h4, 32'hFFC, 1, 3'd2, 2'b01, 0, 0, -1);
        end

        // Reset on beat 5 of 8, then a clean read of the same data
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        axi_write(4'h1, 32'h200, 7, 3'd2, 2'b01, 7, 1'b0);
        axi_read(4'h2, 32'h200, 7, 3'd2, 2'b01, 0, 0, 4);
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        axi_read(4'h3, 32'h200, 7, 3'd2, 2'b01, 0, 0, -1);

        // Random bursts
        for (int t = 0; t < 12; t++) begin
            a   = 32'($urandom_range(0, 32'h17FF));
            len = $urandom_range(0, 15);
            sz  = 3'($urandom_range(0, 2));
            bu  = 2'($urandom_range(0, 3));
            last_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : len;
            for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            axi_write(4'($urandom), a, len, sz, bu, last_at, 1'($urandom_range(0, 1)));
            axi_read(4'($urandom), a, len, sz, bu, 2, 0, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
